// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared opcodes, FSM state encoding and datapath select codes for the multicycle control.
// Latency: n/a (constants, types and one pure decode function only).
// Backpressure: n/a. MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP state to the encoding.
package multicycle_ctrl_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation select, shared with the ALU control block
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // PC input select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_SRC_B        = 2'b00;
    localparam logic [1:0] ALUB_SRC_FOUR     = 2'b01;
    localparam logic [1:0] ALUB_SRC_SIMM     = 2'b10;
    localparam logic [1:0] ALUB_SRC_SIMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,
        S_TRAP   = 4'd12
`endif
    } state_t;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_decoded(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Purpose: Moore decode of FSM state (plus mem_ready in FETCH) into every datapath control line.
// Latency: purely combinational, zero cycles.
// Backpressure: FETCH gates ir_write/pc_write with mem_ready; other states ignore it.
module multicycle_ctrl_outdec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Everything defaults low; each state raises only the lines it owns
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_SRC_B;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        case (state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the IR
                mem_read  = 1'b1;
                alu_src_b = ALUB_SRC_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_SRC_SIMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_SRC_SIMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_SRC_SIMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            default: begin
                // TRAP (when built in) drives nothing
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle MIPS-subset main control FSM with retired-instruction counter.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; outputs combinational from state.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until mem_ready. MULTICYCLE_ILLEGAL_TRAP_EN enables the TRAP state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [CNT_W-1:0]   instr_count,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op
);

    state_t cur_state;
    logic   retire;

    // Flag the edge that leaves the last state of an instruction
    always_comb begin
        retire = 1'b0;
        case (cur_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR:  retire = mem_ready;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_DECODE: retire = 1'b0;
`else
            // Unknown opcodes behave as a two-cycle NOP and still retire
            S_DECODE: retire = ~op_decoded(op);
`endif
            default:  retire = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // State sequencing, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= S_FETCH;
            instr_count <= '0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (cur_state)
                S_FETCH: if (mem_ready) cur_state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_LW || op == OP_SW) cur_state <= S_MEMADR;
                    else if (op == OP_RTYPE)        cur_state <= S_EXEC;
                    else if (op == OP_BEQ)          cur_state <= S_BRANCH;
                    else if (op == OP_ADDI)         cur_state <= S_ADDIEX;
                    else if (op == OP_J)            cur_state <= S_JUMP;
                    else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        cur_state <= S_TRAP;
                        illegal_q <= 1'b1;
`else
                        cur_state <= S_FETCH;
`endif
                    end
                end
                // IR is held stable, so op still distinguishes lw from sw here
                S_MEMADR: cur_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) cur_state <= S_MEMWB;
                S_MEMWB:  cur_state <= S_FETCH;
                S_MEMWR:  if (mem_ready) cur_state <= S_FETCH;
                S_EXEC:   cur_state <= S_ALUWB;
                S_ALUWB:  cur_state <= S_FETCH;
                S_BRANCH: cur_state <= S_FETCH;
                S_ADDIEX: cur_state <= S_ADDIWB;
                S_ADDIWB: cur_state <= S_FETCH;
                S_JUMP:   cur_state <= S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                S_TRAP:   cur_state <= S_TRAP;
`endif
                default:  cur_state <= S_FETCH;
            endcase
        end
    end

    assign state = STATE_W'(cur_state);

    multicycle_ctrl_outdec u_outdec (
        .state         (cur_state),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: self-checking bench for multicycle_ctrl; per-cycle scoreboard of expected state/controls/count.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ready stalls are scripted per cycle in each scoreboard entry.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W   = 4;
    localparam int STATE_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         op;
    logic               mem_ready;
    logic               pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic               mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]         alu_src_b, alu_op, pc_source;
    logic [CNT_W-1:0]   instr_count;
    logic [STATE_W-1:0] state;
    logic               illegal_op;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } ctl_t;

    typedef struct {
        state_t     st;
        logic       mr;
        logic [5:0] o;
        logic       ret;
    } ent_t;

    ctl_t             obs;
    ent_t             sb[$];
    ent_t             e;
    logic [CNT_W-1:0] exp_cnt;
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc;
    int               n_a, n_b;

    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    multicycle_ctrl #(.CNT_W(CNT_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_count(instr_count), .state(state),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference control table written directly from the state descriptions
    function automatic ctl_t exp_ctl(input state_t s, input logic mr);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            S_DECODE: begin c.alu_src_b = 2'b11; end
            S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
            S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
            S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
            S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_ADDIWB: begin c.reg_write = 1; end
            S_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input state_t st, input logic mr, input logic [5:0] o, input logic ret);
        ent_t t;
        t.st = st; t.mr = mr; t.o = o; t.ret = ret;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; op = OP_J;
        repeat (2) @(posedge clk);
        #1; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== S_FETCH || instr_count !== '0 || illegal_op !== 1'b0 || obs !== exp_ctl(S_FETCH, 1'b0)) begin
            n_err++;
            $display("FAIL reset_state: got st=%0d cnt=%0d ill=%b ctl=%h, want st=%0d cnt=0 ill=0 ctl=%h",
                     state, instr_count, illegal_op, obs, S_FETCH, exp_ctl(S_FETCH, 1'b0));
        end
        @(posedge clk); #1;
        rst = 1'b1; exp_cnt = '0;
        repeat (3) push(S_FETCH, 1'b0, OP_J, 1'b0);
        push(S_FETCH, 1'b1, OP_J, 1'b0);
        push(S_DECODE, 1'b0, OP_J, 1'b0);
        push(S_JUMP, 1'b0, OP_J, 1'b1);
        push(S_FETCH, 1'b0, OP_J, 1'b0);
        cyc = 0; n_a = 0; n_b = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            if (ir_write) n_a++;
            if (pc_write && state == S_FETCH) n_b++;
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL reset_stall cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
        n_cmp++;
        if (n_a != 1 || n_b != 1) begin
            n_err++;
            $display("FAIL fetch_pulse: got ir_write cycles=%0d pc_write cycles=%0d, want 1 and 1", n_a, n_b);
        end
    endtask

    task automatic test_lw();
        push(S_FETCH, 1'b1, OP_LW, 1'b0);
        push(S_DECODE, 1'b1, OP_LW, 1'b0);
        push(S_MEMADR, 1'b1, OP_LW, 1'b0);
        push(S_MEMRD, 1'b1, OP_LW, 1'b0);
        push(S_MEMWB, 1'b1, OP_LW, 1'b1);
        push(S_FETCH, 1'b0, OP_LW, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL lw cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
    endtask

    task automatic test_sw_wait();
        push(S_FETCH, 1'b1, OP_SW, 1'b0);
        push(S_DECODE, 1'b0, OP_SW, 1'b0);
        push(S_MEMADR, 1'b0, OP_SW, 1'b0);
        push(S_MEMWR, 1'b0, OP_SW, 1'b0);
        push(S_MEMWR, 1'b0, OP_SW, 1'b0);
        push(S_MEMWR, 1'b1, OP_SW, 1'b1);
        push(S_FETCH, 1'b0, OP_SW, 1'b0);
        cyc = 0; n_a = 0; n_b = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            if (mem_write) n_a++;
            if (reg_write) n_b++;
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL sw_wait cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
        n_cmp++;
        if (n_a != 3 || n_b != 0) begin
            n_err++;
            $display("FAIL sw_enables: got mem_write cycles=%0d reg_write cycles=%0d, want 3 and 0", n_a, n_b);
        end
    endtask

    task automatic test_alu();
        push(S_FETCH, 1'b1, OP_RTYPE, 1'b0);
        push(S_DECODE, 1'b0, OP_RTYPE, 1'b0);
        push(S_EXEC, 1'b0, OP_RTYPE, 1'b0);
        push(S_ALUWB, 1'b1, OP_RTYPE, 1'b1);
        push(S_FETCH, 1'b1, OP_ADDI, 1'b0);
        push(S_DECODE, 1'b1, OP_ADDI, 1'b0);
        push(S_ADDIEX, 1'b0, OP_ADDI, 1'b0);
        push(S_ADDIWB, 1'b0, OP_ADDI, 1'b1);
        push(S_FETCH, 1'b0, OP_ADDI, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL alu cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] start_cnt;
        start_cnt = exp_cnt;
        push(S_FETCH, 1'b1, OP_BEQ, 1'b0);
        push(S_DECODE, 1'b0, OP_BEQ, 1'b0);
        push(S_BRANCH, 1'b0, OP_BEQ, 1'b1);
        push(S_FETCH, 1'b1, OP_J, 1'b0);
        push(S_DECODE, 1'b1, OP_J, 1'b0);
        push(S_JUMP, 1'b1, OP_J, 1'b1);
        push(S_FETCH, 1'b0, OP_J, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL beq_j cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
        n_cmp++;
        if (instr_count !== CNT_W'(start_cnt + 2)) begin
            n_err++;
            $display("FAIL beq_j_count: got %0d, want %0d", instr_count, CNT_W'(start_cnt + 2));
        end
    endtask

    task automatic test_reset_mid();
        push(S_FETCH, 1'b1, OP_LW, 1'b0);
        push(S_DECODE, 1'b1, OP_LW, 1'b0);
        push(S_MEMADR, 1'b1, OP_LW, 1'b0);
        push(S_MEMRD, 1'b0, OP_LW, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
        // Still in MEMRD: memory answers in the same cycle reset lands
        rst = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b0; exp_cnt = '0;
        @(negedge clk);
        n_cmp++;
        if (state !== S_FETCH || reg_write !== 1'b0 || obs !== exp_ctl(S_FETCH, 1'b0) || instr_count !== '0) begin
            n_err++;
            $display("FAIL reset_mid_after: got st=%0d reg_write=%b ctl=%h cnt=%0d, want st=%0d reg_write=0 ctl=%h cnt=0",
                     state, reg_write, obs, instr_count, S_FETCH, exp_ctl(S_FETCH, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            push(S_FETCH, 1'b1, OP_J, 1'b0);
            push(S_DECODE, 1'b1, OP_J, 1'b0);
            push(S_JUMP, 1'b1, OP_J, 1'b1);
        end
        push(S_FETCH, 1'b0, OP_J, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL wrap cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
    endtask

    task automatic test_illegal();
        push(S_FETCH, 1'b1, 6'b111111, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        push(S_DECODE, 1'b1, 6'b111111, 1'b0);
`else
        push(S_DECODE, 1'b1, 6'b111111, 1'b1);
        push(S_FETCH, 1'b0, 6'b111111, 1'b0);
`endif
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr; op = e.o;
            @(negedge clk);
            n_cmp++;
            if (state !== e.st || obs !== exp_ctl(e.st, e.mr) || illegal_op !== 1'b0 || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL illegal cyc%0d: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=0 cnt=%0d",
                         cyc, state, obs, illegal_op, instr_count, e.st, exp_ctl(e.st, e.mr), exp_cnt);
            end
            @(posedge clk); #1;
            if (e.ret) exp_cnt++;
            cyc++;
        end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0]; op = OP_J;
            @(negedge clk);
            n_cmp++;
            if (state !== S_TRAP || illegal_op !== 1'b1 || obs !== ctl_t'(0) || instr_count !== exp_cnt) begin
                n_err++;
                $display("FAIL trap cyc%0d: got st=%0d ill=%b ctl=%h cnt=%0d, want st=%0d ill=1 ctl=0 cnt=%0d",
                         i, state, illegal_op, obs, instr_count, S_TRAP, exp_cnt);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== S_FETCH || illegal_op !== 1'b0 || instr_count !== '0) begin
            n_err++;
            $display("FAIL trap_reset: got st=%0d ill=%b cnt=%0d, want st=%0d ill=0 cnt=0",
                     state, illegal_op, instr_count, S_FETCH);
        end
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b0; op = OP_J; exp_cnt = '0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
